// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a multiplexed active-low 7-segment display bus.
// Synchronise, filter for stability, decode, and age out stale digits.
module seg7_scan_decoder #(
    parameter int DIGITS         = 4,
    parameter int STABLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [6:0]            iv_seg,
    input  logic [DIGITS-1:0]     iv_an,
    output logic [4*DIGITS-1:0]   ov_digits,
    output logic [DIGITS-1:0]     ov_valid,
    output logic [DIGITS-1:0]     ov_blank,
    output logic                  o_update,
    output logic [2:0]            ov_index,
    output logic                  o_error
);

    localparam int SW = DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam int AW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [AW-1:0] AGE_MAX  = AW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD
    } state_e;

    logic [SW-1:0] meta_q;
    logic [SW-1:0] sync_q;
    logic [SW-1:0] prev_q;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    logic [4*DIGITS-1:0]       digits_q, digits_d;
    logic [DIGITS-1:0]         valid_q, valid_d;
    logic [DIGITS-1:0]         blank_q, blank_d;
    logic                      update_q, update_d;
    logic                      error_q, error_d;
    logic [2:0]                index_q, index_d;
    logic [DIGITS-1:0][AW-1:0] age_q, age_d;

    logic [6:0]        pat;
    logic [DIGITS-1:0] an_s;
    logic [3:0]        en_cnt;
    logic [2:0]        en_idx;
    logic [4:0]        lut;
    logic              one_acc;
    logic              multi_acc;

    // Returns {hit, value} for a legal active-high glyph pattern.
    function automatic logic [4:0] glyph_lookup(input logic [6:0] p);
        logic [4:0] r;
        r = 5'h00;
        case (p)
            7'h7E: r = {1'b1, 4'h0};
            7'h30: r = {1'b1, 4'h1};
            7'h6D: r = {1'b1, 4'h2};
            7'h79: r = {1'b1, 4'h3};
            7'h33: r = {1'b1, 4'h4};
            7'h5B: r = {1'b1, 4'h5};
            7'h5F: r = {1'b1, 4'h6};
            7'h70: r = {1'b1, 4'h7};
            7'h7F: r = {1'b1, 4'h8};
            7'h73: r = {1'b1, 4'h9};
            7'h77: r = {1'b1, 4'hA};
            7'h1F: r = {1'b1, 4'hB};
            7'h4E: r = {1'b1, 4'hC};
            7'h3D: r = {1'b1, 4'hD};
            7'h4F: r = {1'b1, 4'hE};
            7'h47: r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    assign pat  = ~sync_q[6:0];
    assign an_s = sync_q[SW-1:7];
    assign lut  = glyph_lookup(pat);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (sync_q != prev_q) begin
            state_d = SETTLE;
            cnt_d   = '0;
        end else if (state_q == SETTLE) begin
            if (cnt_q == CNT_LAST) begin
                accept  = 1'b1;
                state_d = HELD;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        en_cnt = 4'd0;
        en_idx = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_s[i]) begin
                en_cnt = en_cnt + 4'd1;
                en_idx = 3'(i);
            end
        end
    end

    assign one_acc   = accept && (en_cnt == 4'd1);
    assign multi_acc = accept && (en_cnt > 4'd1);

    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        blank_d  = blank_q;
        index_d  = index_q;
        update_d = 1'b0;
        error_d  = 1'b0;
        age_d    = age_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (age_q[i] != AGE_MAX) begin
                age_d[i] = age_q[i] + 1'b1;
            end
            if (age_d[i] == AGE_MAX) begin
                valid_d[i] = 1'b0;
            end
            // An accept on this digit overrides a same-cycle timeout.
            if (one_acc && !an_s[i]) begin
                age_d[i] = '0;
                if (lut[4]) begin
                    digits_d[4*i +: 4] = lut[3:0];
                    valid_d[i]         = 1'b1;
                    blank_d[i]         = 1'b0;
                end else if (pat == 7'h00) begin
                    digits_d[4*i +: 4] = 4'h0;
                    valid_d[i]         = 1'b1;
                    blank_d[i]         = 1'b1;
                end else begin
                    valid_d[i] = 1'b0;
                    blank_d[i] = 1'b0;
                end
            end
        end
        if (multi_acc) begin
            error_d = 1'b1;
            index_d = 3'd0;
        end else if (one_acc) begin
            index_d = en_idx;
            if (lut[4] || (pat == 7'h00)) begin
                update_d = 1'b1;
            end else begin
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q   <= '0;
            sync_q   <= '0;
            prev_q   <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            digits_q <= '0;
            valid_q  <= '0;
            blank_q  <= '0;
            update_q <= 1'b0;
            error_q  <= 1'b0;
            index_q  <= 3'd0;
            age_q    <= '0;
        end else begin
            meta_q   <= {iv_an, iv_seg};
            sync_q   <= meta_q;
            prev_q   <= sync_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            blank_q  <= blank_d;
            update_q <= update_d;
            error_q  <= error_d;
            index_q  <= index_d;
            age_q    <= age_d;
        end
    end

    assign ov_digits = digits_q;
    assign ov_valid  = valid_q;
    assign ov_blank  = blank_q;
    assign o_update  = update_q;
    assign o_error   = error_q;
    assign ov_index  = index_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: stimulus pushes expected events,
// a monitor pops them whenever the decoder pulses update or error.
module tb_seg7_scan_decoder;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [6:0] iv_seg = 7'h7F;
    logic [3:0] iv_an = 4'hF;

    logic [15:0] ov_digits;
    logic [3:0]  ov_valid;
    logic [3:0]  ov_blank;
    logic        o_update;
    logic [2:0]  ov_index;
    logic        o_error;

    logic [15:0] to_digits;
    logic [3:0]  to_valid;
    logic [3:0]  to_blank;
    logic        to_update;
    logic [2:0]  to_index;
    logic        to_error;

    seg7_scan_decoder #(
        .DIGITS(4), .STABLE_CYCLES(8), .TIMEOUT_CYCLES(65536)
    ) u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .iv_seg(iv_seg), .iv_an(iv_an),
        .ov_digits(ov_digits), .ov_valid(ov_valid), .ov_blank(ov_blank),
        .o_update(o_update), .ov_index(ov_index), .o_error(o_error)
    );

    seg7_scan_decoder #(
        .DIGITS(4), .STABLE_CYCLES(8), .TIMEOUT_CYCLES(64)
    ) u_dut_to (
        .i_clk(i_clk), .i_rst(i_rst), .iv_seg(iv_seg), .iv_an(iv_an),
        .ov_digits(to_digits), .ov_valid(to_valid), .ov_blank(to_blank),
        .o_update(to_update), .ov_index(to_index), .o_error(to_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        err;
        logic [2:0]  idx;
        logic [15:0] dig;
        logic [3:0]  val;
        logic [3:0]  blk;
    } ev_t;

    localparam logic [6:0] GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };
    localparam logic [6:0] FR_P [4] = '{7'h4F, 7'h3D, 7'h7E, 7'h4E};
    localparam logic [3:0] FR_AN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    ev_t         exp_q[$];
    ev_t         mon_ev;
    logic [15:0] m_dig = '0;
    logic [3:0]  m_val = '0;
    logic [3:0]  m_blk = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_ev(input logic err, input int k);
        ev_t e;
        e.err = err;
        e.idx = 3'(k);
        e.dig = m_dig;
        e.val = m_val;
        e.blk = m_blk;
        exp_q.push_back(e);
    endfunction

    function automatic void model_accept(input logic [6:0] p, input logic [3:0] an);
        int nlow;
        int k;
        int v;
        nlow = 0;
        k = 0;
        v = -1;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) begin
                nlow++;
                k = i;
            end
        end
        for (int g = 0; g < 16; g++) begin
            if (GLYPH[g] == p) v = g;
        end
        if (nlow > 1) begin
            push_ev(1'b1, 0);
        end else if (nlow == 1) begin
            if (v >= 0) begin
                m_dig[4*k +: 4] = 4'(v);
                m_val[k] = 1'b1;
                m_blk[k] = 1'b0;
                push_ev(1'b0, k);
            end else if (p == 7'h00) begin
                m_dig[4*k +: 4] = 4'h0;
                m_val[k] = 1'b1;
                m_blk[k] = 1'b1;
                push_ev(1'b0, k);
            end else begin
                m_val[k] = 1'b0;
                m_blk[k] = 1'b0;
                push_ev(1'b1, k);
            end
        end
    endfunction

    // Windows of 12+ cycles are long enough to be accepted.
    task automatic show(input logic [6:0] p, input logic [3:0] an, input int n);
        if (n >= 12) model_accept(p, an);
        iv_seg = ~p;
        iv_an = an;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic latency(input logic [6:0] p, input logic [3:0] an,
                           input logic is_err);
        model_accept(p, an);
        iv_seg = ~p;
        iv_an = an;
        for (int e = 1; e <= 10; e++) begin
            @(posedge i_clk);
            #1;
            check("early_pulse", {30'd0, o_update, o_error}, 32'd0);
        end
        @(posedge i_clk);
        #1;
        check("latency_pulse", {30'd0, o_update, o_error},
              is_err ? 32'd1 : 32'd2);
    endtask

    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst && (o_update || o_error)) begin
                check("pulse_excl", {31'd0, o_update & o_error}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: upd=%0b err=%0b idx=%0d expected none",
                             o_update, o_error, ov_index);
                end else begin
                    mon_ev = exp_q.pop_front();
                    check("ev_error", {31'd0, o_error}, {31'd0, mon_ev.err});
                    check("ev_index", {29'd0, ov_index}, {29'd0, mon_ev.idx});
                    check("ev_digits", {16'd0, ov_digits}, {16'd0, mon_ev.dig});
                    check("ev_valid", {28'd0, ov_valid}, {28'd0, mon_ev.val});
                    check("ev_blank", {28'd0, ov_blank}, {28'd0, mon_ev.blk});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int slot;
        int off;
        logic [3:0] exp_v;

        repeat (2) @(posedge i_clk);
        #1;
        check("rst_outputs", {ov_digits, ov_valid, ov_blank, o_update, o_error, ov_index},
              32'd0);
        i_rst = 1'b0;

        latency(7'h6D, 4'b1110, 1'b0);
        repeat (30) @(posedge i_clk);
        #1;
        check("t1_digit0", {28'd0, ov_digits[3:0]}, 32'h2);
        check("t1_valid", {28'd0, ov_valid}, 32'b0001);

        show(7'h4F, 4'b1110, 100);
        show(7'h00, 4'b1111, 5);
        show(7'h3D, 4'b1101, 100);
        show(7'h00, 4'b1111, 5);
        show(7'h7E, 4'b1011, 100);
        show(7'h00, 4'b1111, 5);
        show(7'h4E, 4'b0111, 100);
        show(7'h00, 4'b1111, 5);
        check("scan_digits", {16'd0, ov_digits}, 32'hC0DE);
        check("scan_valid", {28'd0, ov_valid}, 32'hF);
        check("scan_blank", {28'd0, ov_blank}, 32'h0);

        show(7'h30, 4'b1100, 20);
        check("multi_digits", {16'd0, ov_digits}, 32'hC0DE);
        check("multi_valid", {28'd0, ov_valid}, 32'hF);
        show(7'h00, 4'b1111, 5);
        show(7'h01, 4'b1011, 20);
        check("illegal_valid", {28'd0, ov_valid}, 32'b1011);
        check("illegal_digits", {16'd0, ov_digits}, 32'hC0DE);

        for (int i = 0; i < 13; i++) begin
            show((i % 2) != 0 ? 7'h30 : 7'h7F, 4'b1101, 3);
        end
        show(7'h30, 4'b1101, 20);
        check("glitch_digits", {16'd0, ov_digits}, 32'hC01E);

        show(7'h00, 4'b0111, 20);
        check("blank_digits", {16'd0, ov_digits}, 32'h001E);
        check("blank_valid", {28'd0, ov_valid}, 32'b1011);
        check("blank_blank", {28'd0, ov_blank}, 32'b1000);

        show(7'h5B, 4'b1011, 6);
        i_rst = 1'b1;
        #1;
        check("midrst_outputs",
              {ov_digits, ov_valid, ov_blank, o_update, o_error, ov_index}, 32'd0);
        check("midrst_queue", exp_q.size(), 32'd0);
        m_dig = '0;
        m_val = '0;
        m_blk = '0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        latency(7'h5B, 4'b1011, 1'b0);
        repeat (80) @(posedge i_clk);
        #1;

        for (int e = 0; e < 160; e++) begin
            slot = e / 19;
            off = e % 19;
            if (off == 0 && slot < 4) model_accept(FR_P[slot], FR_AN[slot]);
            if (slot < 4 && off < 14) begin
                iv_seg = ~FR_P[slot];
                iv_an = FR_AN[slot];
            end else begin
                iv_seg = 7'h7F;
                iv_an = 4'hF;
            end
            @(posedge i_clk);
            #1;
            exp_v = 4'h0;
            for (int k = 0; k < 4; k++) begin
                if (e + 1 >= k * 19 + 11 && e + 1 < k * 19 + 75) exp_v[k] = 1'b1;
            end
            check("timeout_valid", {28'd0, to_valid}, {28'd0, exp_v});
        end
        check("timeout_digits", {16'd0, to_digits}, 32'hC0DE);
        check("timeout_blank", {28'd0, to_blank}, 32'h0);

        repeat (5) @(posedge i_clk);
        #1;
        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
